bbo_snapshot_serializer: RTL



---
 rtl/bbo_snapshot_serializer_pkg.sv | 29 ++
 rtl/bbo_snapshot_serializer_frame_byte_mux.sv | 51 +++++
 rtl/bbo_snapshot_serializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bbo_snapshot_serializer_pkg.sv
// Shared types and constants for the BBO snapshot serializer.
//   bbo_snapshot_t : best bid/ask price and qty, 32 bits each
//   bbo_state_e    : serializer FSM states
//   xor_bytes32    : XOR of the four bytes of a 32-bit word (checksum helper)
package bbo_snapshot_serializer_pkg;

  typedef struct packed {
    logic [31:0] bid_px;
    logic [31:0] bid_qty;
    logic [31:0] ask_px;
    logic [31:0] ask_qty;
  } bbo_snapshot_t;

  localparam int          BBO_FRAME_LEN = 21;
  localparam logic [7:0]  BBO_SYNC      = 8'hA5;
  localparam logic [7:0]  BBO_MSG_TYPE  = 8'h01;
  localparam logic [4:0]  BBO_LAST_IDX  = 5'(BBO_FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } bbo_state_e;

  function automatic logic [7:0] xor_bytes32(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

endpackage

// File: rtl/bbo_snapshot_serializer_frame_byte_mux.sv
// Combinational frame byte selector: maps (snapshot, seq, byte index) to the
// byte presented on the stream, including the trailing checksum.
//   snap_i : frame shadow snapshot
//   seq_i  : sequence number stamped into bytes 2-3
//   idx_i  : byte index 0..20
//   byte_o : selected frame byte (0 for out-of-range index)
module bbo_frame_byte_mux
  import bbo_snapshot_serializer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = BBO_SYNC,
  parameter logic [7:0] MSG_TYPE  = BBO_MSG_TYPE
) (
  input  bbo_snapshot_t snap_i,
  input  logic [15:0]   seq_i,
  input  logic [4:0]    idx_i,
  output logic [7:0]    byte_o
);

  logic [4:0]  off;
  logic [31:0] word;
  logic [7:0]  csum;

  // Payload bytes 4..19 are four little-endian words; off selects word/byte.
  assign off = idx_i - 5'd4;

  always_comb begin
    word = 32'h0;
    case (off[3:2])
      2'd0:    word = snap_i.bid_px;
      2'd1:    word = snap_i.bid_qty;
      2'd2:    word = snap_i.ask_px;
      default: word = snap_i.ask_qty;
    endcase
  end

  // XOR of bytes 1..19, derived directly from the stable shadow and seq.
  assign csum = MSG_TYPE ^ seq_i[7:0] ^ seq_i[15:8]
              ^ xor_bytes32(snap_i.bid_px) ^ xor_bytes32(snap_i.bid_qty)
              ^ xor_bytes32(snap_i.ask_px) ^ xor_bytes32(snap_i.ask_qty);

  always_comb begin
    byte_o = 8'h00;
    if (idx_i == 5'd0)              byte_o = SYNC_BYTE;
    else if (idx_i == 5'd1)         byte_o = MSG_TYPE;
    else if (idx_i == 5'd2)         byte_o = seq_i[7:0];
    else if (idx_i == 5'd3)         byte_o = seq_i[15:8];
    else if (idx_i <= 5'd19)        byte_o = word[8*off[1:0] +: 8];
    else if (idx_i == BBO_LAST_IDX) byte_o = csum;
  end

endmodule

// File: rtl/bbo_snapshot_serializer.sv
// Top-of-book snapshot serializer. Captures best bid/ask on each book update
// strobe, drops unchanged snapshots, coalesces bursts into one pending slot
// and streams each snapshot as a 21-byte framed message.
//   clk, rst                      : clock, synchronous active-high reset
//   book_update, best_*           : snapshot strobe and fields
//   m_axis_tdata/tvalid/tready/tlast : byte stream out
//   busy                          : frame in flight or snapshot pending
//   frames_sent, snaps_coalesced  : wrapping event counters
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | waiting; loads shadow from pending when pending set
// ST_SEND | presenting byte[idx], advances on handshake
// ST_DONE | frame complete; bump frames_sent and seq
module bbo_snapshot_serializer
  import bbo_snapshot_serializer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = BBO_SYNC,
  parameter logic [7:0] MSG_TYPE     = BBO_MSG_TYPE,
  parameter bit         SUPPRESS_DUP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        book_update,
  input  logic [31:0] best_bid_price,
  input  logic [31:0] best_bid_qty,
  input  logic [31:0] best_ask_price,
  input  logic [31:0] best_ask_qty,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic [31:0] snaps_coalesced
);

  bbo_state_e    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [15:0]   seq_q, seq_d;
  logic          pending_q, pending_d;
  bbo_snapshot_t pend_snap_q, pend_snap_d;
  bbo_snapshot_t last_snap_q, last_snap_d;
  bbo_snapshot_t shadow_q, shadow_d;
  logic [31:0]   frames_q, frames_d;
  logic [31:0]   coal_q, coal_d;

  bbo_snapshot_t snap_in;
  logic          is_dup, capture, consume;
  logic [7:0]    mux_byte;

  assign snap_in = {best_bid_price, best_bid_qty, best_ask_price, best_ask_qty};
  assign is_dup  = SUPPRESS_DUP && (snap_in == last_snap_q);
  assign capture = book_update && !is_dup;
  assign consume = (state_q == ST_IDLE) && pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      seq_q       <= '0;
      pending_q   <= 1'b0;
      pend_snap_q <= '0;
      last_snap_q <= '0;
      shadow_q    <= '0;
      frames_q    <= '0;
      coal_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      pending_q   <= pending_d;
      pend_snap_q <= pend_snap_d;
      last_snap_q <= last_snap_d;
      shadow_q    <= shadow_d;
      frames_q    <= frames_d;
      coal_q      <= coal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    pending_d   = pending_q;
    pend_snap_d = pend_snap_q;
    last_snap_d = last_snap_q;
    shadow_d    = shadow_q;
    frames_d    = frames_q;
    coal_d      = coal_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          shadow_d  = pend_snap_q;
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (idx_q == BBO_LAST_IDX) state_d = ST_DONE;
          else                       idx_d   = idx_q + 5'd1;
        end
      end
      ST_DONE: begin
        frames_d = frames_q + 32'd1;
        seq_d    = seq_q + 16'd1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A capture in the same cycle as a consume refills pending without
    // counting as a coalesce; the old pending value already went to shadow.
    if (capture) begin
      pend_snap_d = snap_in;
      last_snap_d = snap_in;
      pending_d   = 1'b1;
      if (pending_q && !consume) coal_d = coal_q + 32'd1;
    end
  end

  bbo_frame_byte_mux #(
    .SYNC_BYTE(SYNC_BYTE),
    .MSG_TYPE (MSG_TYPE)
  ) u_byte_mux (
    .snap_i(shadow_q),
    .seq_i (seq_q),
    .idx_i (idx_q),
    .byte_o(mux_byte)
  );

  assign m_axis_tvalid   = (state_q == ST_SEND);
  assign m_axis_tdata    = m_axis_tvalid ? mux_byte : 8'h00;
  assign m_axis_tlast    = m_axis_tvalid && (idx_q == BBO_LAST_IDX);
  assign busy            = (state_q != ST_IDLE) || pending_q;
  assign frames_sent     = frames_q;
  assign snaps_coalesced = coal_q;

endmodule
